ei_tdp_ram_port_master: RTL and testbench
=========================================

// Module: ei_tdp_ram_port_master
// PURPOSE
//  Initiator for one port of the TDP RAM. Accepts burst read/write commands on a valid/ready
//  command channel and issues per-beat we/re/addr/data to the RAM port. Streams write data in and
//  read data out via valid/ready channels. Sits between the testbench/system agent and ram port A or B.
// PARAMETERS
//  DATA_WIDTH  8   RAM data width
//  ADDR_WIDTH  10  RAM address width
//  LEN_WIDTH   4   burst length field width; beats = cmd_len+1 (1..2**LEN_WIDTH)
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  reset      in   1           asynchronous, active-high reset
//  cmd_valid  in   1           command valid
//  cmd_ready  out  1           command accepted when valid&&ready
//  cmd_we     in   1           1=write burst, 0=read burst
//  cmd_addr   in   ADDR_WIDTH  start address
//  cmd_len    in   LEN_WIDTH   beats-1
//  wd_valid   in   1           write-data beat valid
//  wd_ready   out  1           write-data beat accepted when valid&&ready
//  wd_data    in   DATA_WIDTH  write-data beat
//  rd_valid   out  1           read-data beat valid
//  rd_ready   in   1           read-data beat consumed when valid&&ready
//  rd_data    out  DATA_WIDTH  read-data beat
//  done       out  1           1-cycle pulse, burst fully complete
//  ram_addr   out  ADDR_WIDTH  to RAM addr
//  ram_data   out  DATA_WIDTH  to RAM data
//  ram_we     out  1           to RAM we
//  ram_re     out  1           to RAM re
//  ram_q      in   DATA_WIDTH  from RAM q (valid 1 cycle after ram_re)
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_ready=0 during reset, 1 the first cycle after). FIFO emptied, in-flight
//   flag cleared, FSM->IDLE. Reset mid-burst aborts the burst; no done pulse; no further RAM strobes.
//  FSM: IDLE -> (cmd accept) WR or RD; WR/RD -> DRAIN after last beat issued; DRAIN -> IDLE with done=1.
//  IDLE: cmd_ready=1. On accept: latch addr, len, we; beat counter=0. cmd_ready=0 in all other states.
//  WR: wd_ready=1. Each wd handshake drives ram_we=1, ram_addr=cur, ram_data=wd_data that same cycle
//   (combinational from handshake). No handshake -> ram_we=0. Last beat (cnt==len) -> DRAIN.
//  RD: ram_re=1, ram_addr=cur when (fifo_count + inflight) < 2; inflight set for one cycle; next cycle
//   ram_q is pushed into 2-entry read FIFO. Head of FIFO drives rd_valid/rd_data. rd_ready held 1
//   gives 1 beat/cycle; rd_ready=0 stalls issue after at most 2 beats outstanding; no beat dropped.
//  Address: cur increments by 1 per issued beat, wraps 2**ADDR_WIDTH-1 -> 0 (mod 2**ADDR_WIDTH).
//  DRAIN: wait until inflight==0 and FIFO empty (all read beats consumed); then done=1 for one cycle
//   and IDLE; cmd_ready=1 from the following cycle. Write bursts pass DRAIN in 1 cycle.
//  ram_we and ram_re never both 1. wd_ready=0 outside WR. rd_valid only in RD/DRAIN.
//  Simultaneous FIFO push and pop: count unchanged, order preserved.
//  Command latency: accept at cycle N -> first RAM strobe no earlier than N+1.
// TESTING
//  1 Reset: assert reset mid-RD burst len=7 -> all outputs 0 immediately, no done; release -> cmd_ready=1.
//  2 Write len=3 addr=0x010, wd 0xA1..0xA4 back-to-back -> ram_we 4 cycles, addr 0x010..0x013; done once.
//  3 Read len=3 addr=0x010, rd_ready=1 -> rd_data A1,A2,A3,A4 on 4 consecutive cycles, then done.
//  4 Read len=15 with rd_ready toggled 1/0 randomly -> all 16 beats in order, never >2 outstanding.
//  5 Write len=2 addr=0x3FF data 11,22,33 -> writes at 0x3FF,0x000,0x001; readback matches (wrap).
//  6 cmd_valid held during burst -> cmd_ready=0 until cycle after done; next command accepted then.

Source files
------------

// File: rtl/ei_tdp_ram_port_master_if.sv
// Command, write-data, read-data and RAM-port signals of one TDP RAM port initiator.
// master: the initiator's view; slave: the agent plus RAM side.
interface ei_tdp_ram_port_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wd_valid;
    logic                  wd_ready;
    logic [DATA_WIDTH-1:0] wd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, ram_q,
        output cmd_ready, wd_ready, rd_valid, rd_data, done, ram_addr, ram_data, ram_we, ram_re
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, ram_q,
        input  cmd_ready, wd_ready, rd_valid, rd_data, done, ram_addr, ram_data, ram_we, ram_re
    );
endinterface

// File: rtl/ei_tdp_ram_port_master.sv
// Burst initiator for one TDP RAM port: turns read/write burst commands into per-beat RAM
// strobes, with write data streamed in and read data returned through a 2-entry FIFO.
module ei_tdp_ram_port_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    ei_tdp_ram_port_master_if.master       bus
);

    typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur;
    logic [LEN_WIDTH-1:0]  len, cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wptr, rptr;
    logic [1:0]            fifo_count;

    logic cmd_ready, wd_ready, done;
    logic accept, wr_fire, rd_issue, beat, push, pop, last_beat, drained;

    assign accept    = bus.cmd_valid & cmd_ready;
    assign wr_fire   = (state == WR) & bus.wd_valid;
    assign pop       = (fifo_count != 2'd0) & bus.rd_ready;
    assign push      = inflight;
    // A beat popped this cycle frees its slot, so a steady rd_ready sustains one beat per cycle.
    assign rd_issue  = (state == RD) &&
                       (({1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);
    assign beat      = wr_fire | rd_issue;
    assign last_beat = (cnt == len);
    assign drained   = (fifo_count == 2'd0) & ~inflight;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted, up the moment it releases.
                cmd_ready = ~reset;
                if (bus.cmd_valid && !reset) state_nx = bus.cmd_we ? WR : RD;
            end
            WR: begin
                wd_ready = 1'b1;
                if (wr_fire && last_beat) state_nx = DRAIN;
            end
            RD: begin
                if (rd_issue && last_beat) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drained) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= '0;
            len         <= '0;
            cnt         <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            inflight <= rd_issue;
            if (accept) begin
                cur <= bus.cmd_addr;
                len <= bus.cmd_len;
                cnt <= '0;
            end else if (beat) begin
                cur <= cur + ADDR_WIDTH'(1);
                cnt <= cnt + LEN_WIDTH'(1);
            end
            // ram_q is valid the cycle after ram_re, which is exactly when inflight is set.
            if (push) begin
                fifo_mem[wptr] <= bus.ram_q;
                wptr           <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.wd_ready  = wd_ready;
    assign bus.done      = done;
    assign bus.rd_valid  = (fifo_count != 2'd0);
    assign bus.rd_data   = fifo_mem[rptr];
    assign bus.ram_we    = wr_fire;
    assign bus.ram_re    = rd_issue;
    assign bus.ram_addr  = beat ? cur : '0;
    assign bus.ram_data  = wr_fire ? bus.wd_data : '0;

endmodule

// File: tb/tb_ei_tdp_ram_port_master.sv
// Bench for ei_tdp_ram_port_master: burst table, hand-written reset/hold sequences and random
// bursts checked against a flat memory model of what each burst should write or return.
module tb_ei_tdp_ram_port_master;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int LW = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ei_tdp_ram_port_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ei_tdp_ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM port behaviour: write on we, registered read data one cycle after re.
    logic [DW-1:0] ram     [DEPTH] = '{default: '0};
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_data;
        if (bus.ram_re) bus.ram_q <= ram[bus.ram_addr];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return {bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.rd_data, bus.done,
                bus.ram_addr, bus.ram_data, bus.ram_we, bus.ram_re};
    endfunction

    // dat: write beats to send, or read beats expected back.
    task automatic run_burst(input string tag, input logic we, input logic [AW-1:0] a,
                             input logic [LW-1:0] l, input logic stall, input logic hold,
                             input logic pre, input logic [15:0][DW-1:0] dat,
                             input logic [AW-1:0] exp_last);
        int issued, consumed, wi, maxo, early, bad, first_c, last_c, rf, rl;
        logic acc, fin, addr_ok, data_ok, lat_ok;
        logic [AW-1:0] last_a;
        issued = 0; consumed = 0; wi = 0; maxo = 0; early = 0; bad = 0;
        first_c = -1; last_c = -1; rf = -1; rl = -1;
        acc = pre; fin = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; lat_ok = 1'b1; last_a = '0;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            bus.cmd_valid = hold | ~acc;
            bus.cmd_we    = we;
            bus.cmd_addr  = a;
            bus.cmd_len   = l;
            bus.wd_valid  = we && (wi <= int'(l)) && (!stall || $urandom_range(0, 1) == 1);
            bus.wd_data   = dat[wi[3:0]];
            bus.rd_ready  = !stall || $urandom_range(0, 1) == 1;
            #1;
            if (bus.ram_we && bus.ram_re) bad++;
            if (bus.ram_we || bus.ram_re) begin
                if (bus.ram_re == we) bad++;
                if (bus.ram_addr !== AW'((int'(a) + issued) % DEPTH)) addr_ok = 1'b0;
                if (bus.ram_we && bus.ram_data !== dat[issued[3:0]]) data_ok = 1'b0;
                if (!acc) lat_ok = 1'b0;
                if (first_c < 0) first_c = c;
                last_c = c;
                last_a = bus.ram_addr;
                issued++;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (we || bus.rd_data !== dat[consumed[3:0]]) data_ok = 1'b0;
                if (rf < 0) rf = c;
                rl = c;
                consumed++;
            end
            if (!we && (issued - consumed) > maxo) maxo = issued - consumed;
            if (acc && bus.cmd_ready) early++;
            if (bus.done) fin = 1'b1;
            if (bus.wd_valid && bus.wd_ready) wi++;
            if (bus.cmd_valid && bus.cmd_ready) acc = 1'b1;
        end
        chk({tag, " done seen"}, 32'(fin), 32'd1);
        chk({tag, " beats issued"}, 32'(issued), 32'(int'(l) + 1));
        if (!we) chk({tag, " beats returned"}, 32'(consumed), 32'(int'(l) + 1));
        chk({tag, " beat addresses"}, 32'(addr_ok), 32'd1);
        chk({tag, " beat data"}, 32'(data_ok), 32'd1);
        chk({tag, " last address"}, 32'(last_a), 32'(exp_last));
        chk({tag, " strobe after accept"}, 32'(lat_ok), 32'd1);
        chk({tag, " strobe kind"}, 32'(bad), 32'd0);
        chk({tag, " cmd_ready low while busy"}, 32'(early), 32'd0);
        if (!stall) chk({tag, " back-to-back"}, 32'(we ? last_c - first_c : rl - rf), 32'(l));
        if (!we) chk({tag, " outstanding<=2"}, 32'(maxo <= 2), 32'd1);
        // Cycle after done: IDLE again; a held command is replaced by a 1-beat read at a.
        @(negedge clk);
        bus.cmd_valid = hold;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.rd_ready  = 1'b1;
        #1;
        chk({tag, " cmd_ready after done"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, " done single pulse"}, 32'(bus.done), 32'd0);
        if (we)
            for (int i = 0; i <= int'(l); i++) ref_mem[(int'(a) + i) % DEPTH] = dat[i];
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic          stall;
        logic [DW-1:0] d0;       // beat i data = d0 + i*step
        logic [DW-1:0] step;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vec [8];
    logic [15:0][DW-1:0] dat;
    logic          rwe, rst_l;
    logic [AW-1:0] ra, rlast;
    logic [LW-1:0] rlen;
    int            quiet;

    initial begin
        vec[0] = '{1'b1, 10'h010, 4'd3,  1'b0, 8'hA1, 8'h01, 10'h013};
        vec[1] = '{1'b0, 10'h010, 4'd3,  1'b0, 8'hA1, 8'h01, 10'h013};
        vec[2] = '{1'b1, 10'h3FF, 4'd2,  1'b0, 8'h11, 8'h11, 10'h001};
        vec[3] = '{1'b0, 10'h3FF, 4'd2,  1'b0, 8'h11, 8'h11, 10'h001};
        vec[4] = '{1'b1, 10'h100, 4'd15, 1'b1, 8'h40, 8'h03, 10'h10F};
        vec[5] = '{1'b0, 10'h100, 4'd15, 1'b1, 8'h40, 8'h03, 10'h10F};
        vec[6] = '{1'b0, 10'h011, 4'd1,  1'b0, 8'hA2, 8'h01, 10'h012};
        vec[7] = '{1'b0, 10'h000, 4'd0,  1'b1, 8'h22, 8'h00, 10'h000};

        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wd_valid = 1'b0; bus.wd_data = '0; bus.rd_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("outputs in reset", outs(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("cmd_ready after reset", 32'(bus.cmd_ready), 32'd1);

        // Reset in the middle of an 8-beat read with the consumer stalled.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 10'h010; bus.cmd_len = 4'd7;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("read beat pending before reset", 32'(bus.rd_valid), 32'd1);
        reset = 1'b1;
        #1 chk("outputs at mid-burst reset", outs(), 32'd0);
        quiet = 0;
        repeat (2) begin
            @(negedge clk);
            #1 if (outs() != 32'd0) quiet++;
        end
        @(negedge clk);
        reset = 1'b0;
        bus.rd_ready = 1'b1;
        #1 chk("cmd_ready after mid-burst reset", 32'(bus.cmd_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            #1 if (bus.done || bus.ram_we || bus.ram_re || bus.rd_valid) quiet++;
        end
        chk("aborted burst stays silent", 32'(quiet), 32'd0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) dat[i] = vec[v].d0 + DW'(i) * vec[v].step;
            run_burst($sformatf("vec%0d", v), vec[v].we, vec[v].addr, vec[v].len,
                      vec[v].stall, 1'b0, 1'b0, dat, vec[v].exp_last);
        end

        // cmd_valid held through a write; the follow-up read is taken the cycle after done.
        dat = '0;
        dat[0] = 8'h05; dat[1] = 8'h06;
        run_burst("hold write", 1'b1, 10'h200, 4'd1, 1'b0, 1'b1, 1'b0, dat, 10'h201);
        dat = '0;
        dat[0] = 8'h05;
        run_burst("hold read", 1'b0, 10'h200, 4'd0, 1'b0, 1'b0, 1'b1, dat, 10'h200);

        for (int k = 0; k < 24; k++) begin
            rwe   = 1'($urandom_range(0, 1));
            ra    = (k % 4 == 0) ? AW'(10'h3F8 + $urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
            rlen  = LW'($urandom_range(0, 15));
            rst_l = 1'($urandom_range(0, 1));
            rlast = AW'((int'(ra) + int'(rlen)) % DEPTH);
            for (int i = 0; i < 16; i++)
                dat[i] = rwe ? DW'($urandom) : ref_mem[(int'(ra) + i) % DEPTH];
            run_burst($sformatf("rand%0d", k), rwe, ra, rlen, rst_l, 1'b0, 1'b0, dat, rlast);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
